// File: rtl/scan_conv_sequencer.sv
// Frame sequencer for the Cartesian-to-polar scan-conversion core: walks the raster,
// pulses Start per pixel, captures core results after a fixed latency and streams them out.
module scan_conv_sequencer #(
  parameter int W            = 12,
  parameter int X_MAX        = 480,
  parameter int Y_MAX        = 640,
  parameter int CORE_LATENCY = 19,
  parameter int CW           = 19
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          Go,
  input  logic          Abort,
  output logic [W-1:0]  X_Inp,
  output logic [W-1:0]  Y_Inp,
  output logic          Start,
  input  logic [W-1:0]  R_Otp,
  input  logic [W-1:0]  The_Otp,
  output logic          Pix_Valid,
  input  logic          Pix_Ready,
  output logic [W-1:0]  Pix_X,
  output logic [W-1:0]  Pix_Y,
  output logic [W-1:0]  Pix_R,
  output logic [W-1:0]  Pix_The,
  output logic          Busy,
  output logic          Frame_Done,
  output logic [CW-1:0] Pix_Count
);
  localparam int LW = (CORE_LATENCY < 1) ? 1 : $clog2(CORE_LATENCY + 1);
  localparam logic [W-1:0]  XM  = W'(X_MAX);
  localparam logic [W-1:0]  YM  = W'(Y_MAX);
  localparam logic [LW-1:0] LAT = LW'(CORE_LATENCY);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUTPUT, DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   x_q, x_d, y_q, y_d;
  logic [LW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   x_inp_q, x_inp_d, y_inp_q, y_inp_d;
  logic           start_q, start_d, pix_valid_q, pix_valid_d;
  logic [W-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d, pix_r_q, pix_r_d, pix_the_q, pix_the_d;
  logic           busy_q, busy_d, frame_done_q, frame_done_d;
  logic [CW-1:0]  pix_count_q, pix_count_d;
  logic           hs, last;

  // Pix_Valid is high exactly in OUTPUT, so the handshake can be taken from the state
  assign hs   = (state_q == OUTPUT) && Pix_Ready;
  assign last = (x_q == XM) && (y_q == YM);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      x_inp_q      <= '0;
      y_inp_q      <= '0;
      start_q      <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_r_q      <= '0;
      pix_the_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cnt_q        <= cnt_d;
      x_inp_q      <= x_inp_d;
      y_inp_q      <= y_inp_d;
      start_q      <= start_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_r_q      <= pix_r_d;
      pix_the_q    <= pix_the_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Go) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == LW'(1)) state_d = OUTPUT;
      OUTPUT:  if (hs) state_d = last ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Abort) state_d = IDLE;
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    cnt_d       = cnt_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_r_d     = pix_r_q;
    pix_the_d   = pix_the_q;
    pix_count_d = pix_count_q;
    case (state_q)
      IDLE: if (Go) begin
        x_d         = '0;
        y_d         = '0;
        pix_count_d = '0;
      end
      ISSUE: cnt_d = LAT;
      WAIT: begin
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          pix_x_d   = x_q;
          pix_y_d   = y_q;
          pix_r_d   = R_Otp;
          pix_the_d = The_Otp;
        end
      end
      OUTPUT: if (hs) begin
        pix_count_d = pix_count_q + CW'(1);
        // the final pixel parks the walker at the origin instead of stepping past X_MAX
        if (last) begin
          x_d = '0;
          y_d = '0;
        end else if (y_q < YM) begin
          y_d = y_q + W'(1);
        end else begin
          y_d = '0;
          x_d = x_q + W'(1);
        end
      end
      default: ;
    endcase
    if (Abort) begin
      x_d         = '0;
      y_d         = '0;
      cnt_d       = '0;
      pix_count_d = pix_count_q;
    end
    start_d      = (state_d == ISSUE);
    x_inp_d      = start_d ? x_d : x_inp_q;
    y_inp_d      = start_d ? y_d : y_inp_q;
    pix_valid_d  = (state_d == OUTPUT);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  assign X_Inp      = x_inp_q;
  assign Y_Inp      = y_inp_q;
  assign Start      = start_q;
  assign Pix_Valid  = pix_valid_q;
  assign Pix_X      = pix_x_q;
  assign Pix_Y      = pix_y_q;
  assign Pix_R      = pix_r_q;
  assign Pix_The    = pix_the_q;
  assign Busy       = busy_q;
  assign Frame_Done = frame_done_q;
  assign Pix_Count  = pix_count_q;
endmodule
